// File: rtl/resp_id_tracker.sv
// In-order response router for a TCDM arbitration tree. It records the initiator ID of each
// accepted request and steers every returning response to the initiator that issued it.
module resp_id_tracker #(
  parameter int unsigned N_MASTER   = 8,
  parameter int unsigned ID_WIDTH   = 3,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // request side
  input  logic                  data_req_i,
  input  logic [ID_WIDTH-1:0]   ID_i,
  input  logic                  data_gnt_i,
  output logic                  data_req_o,
  output logic                  data_gnt_o,
  // response side
  input  logic                  r_valid_i,
  input  logic [DATA_WIDTH-1:0] r_rdata_i,
  output logic [N_MASTER-1:0]   r_valid_o,
  output logic [DATA_WIDTH-1:0] r_rdata_o,
  output logic [ID_WIDTH-1:0]   r_ID_o,
  // status
  output logic [CNT_WIDTH-1:0]  outstanding_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  err_o
);

  localparam int unsigned PtrWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrWidth-1:0]  PtrOne  = PtrWidth'(1);
  localparam logic [PtrWidth-1:0]  PtrLast = PtrWidth'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CntFull = CNT_WIDTH'(DEPTH);
  localparam logic [N_MASTER-1:0]  OneHot0 = N_MASTER'(1);

  logic [ID_WIDTH-1:0]  id_mem_q [DEPTH];
  logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic                 full, empty;
  logic                 push, pop;
  logic [ID_WIDTH-1:0]  head_id;

  assign full  = (cnt_q == CntFull);
  assign empty = (cnt_q == '0);

  // Handshake masking: nothing reaches the target while there is no slot for its ID.
  assign data_req_o = data_req_i & ~full;
  assign data_gnt_o = data_gnt_i & ~full;

  assign push = data_req_o & data_gnt_i;
  // A response can only retire an entry that existed before this cycle (no bypass).
  assign pop  = r_valid_i & ~empty;

  // Head ID forced to zero when empty so the output never reflects uninitialised storage.
  assign head_id = empty ? '0 : id_mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrOne;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrOne;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntOne;
      2'b01:   cnt_d = cnt_q - CntOne;
      default: cnt_d = cnt_q;
    endcase
  end

  assign err_d = err_q | (r_valid_i & empty);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // ID storage is not reset; validity is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      id_mem_q[wr_ptr_q] <= ID_i;
    end
  end

  assign r_valid_o     = pop ? (OneHot0 << head_id) : '0;
  assign r_rdata_o     = r_rdata_i;
  assign r_ID_o        = head_id;
  assign outstanding_o = cnt_q;
  assign full_o        = full;
  assign empty_o       = empty;
  assign err_o         = err_q;

endmodule

// File: tb/tb_resp_id_tracker.sv
// Directed bench for resp_id_tracker: ordering, full/empty masking, error flag and reset.
module tb_resp_id_tracker;

  logic        clk;
  logic        rst_n;
  logic        data_req_i;
  logic [2:0]  ID_i;
  logic        data_gnt_i;
  logic        data_req_o;
  logic        data_gnt_o;
  logic        r_valid_i;
  logic [31:0] r_rdata_i;
  logic [7:0]  r_valid_o;
  logic [31:0] r_rdata_o;
  logic [2:0]  r_ID_o;
  logic [2:0]  outstanding_o;
  logic        full_o;
  logic        empty_o;
  logic        err_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  resp_id_tracker #(
    .N_MASTER  (8),
    .ID_WIDTH  (3),
    .DATA_WIDTH(32),
    .DEPTH     (4),
    .CNT_WIDTH (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_req_i   (data_req_i),
    .ID_i         (ID_i),
    .data_gnt_i   (data_gnt_i),
    .data_req_o   (data_req_o),
    .data_gnt_o   (data_gnt_o),
    .r_valid_i    (r_valid_i),
    .r_rdata_i    (r_rdata_i),
    .r_valid_o    (r_valid_o),
    .r_rdata_o    (r_rdata_o),
    .r_ID_o       (r_ID_o),
    .outstanding_o(outstanding_o),
    .full_o       (full_o),
    .empty_o      (empty_o),
    .err_o        (err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    data_req_i = 1'b0;
    data_gnt_i = 1'b0;
    ID_i       = 3'd0;
    r_valid_i  = 1'b0;
    r_rdata_i  = 32'd0;
  endtask

  task automatic push_id(input logic [2:0] id);
    idle();
    data_req_i = 1'b1;
    data_gnt_i = 1'b1;
    ID_i       = id;
    tick();
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    // Busy inputs during reset must neither push, pop nor flag an error.
    rst_n      = 1'b0;
    data_req_i = 1'b1;
    data_gnt_i = 1'b1;
    ID_i       = 3'd5;
    r_valid_i  = 1'b1;
    r_rdata_i  = 32'h55;
    tick();
    tick();
    rst_n = 1'b1;
    idle();
    #1;
    total_cnt++;
    if (outstanding_o !== 3'd0) $display("FAIL rst_cnt got %0d want 0", outstanding_o);
    else pass_cnt++;
    total_cnt++;
    if (empty_o !== 1'b1 || full_o !== 1'b0)
      $display("FAIL rst_flags got empty=%b full=%b want empty=1 full=0", empty_o, full_o);
    else pass_cnt++;
    total_cnt++;
    if (err_o !== 1'b0) $display("FAIL rst_err got %b want 0", err_o);
    else pass_cnt++;
    total_cnt++;
    if (r_valid_o !== 8'h00 || $isunknown(r_ID_o))
      $display("FAIL rst_resp got r_valid_o=%h r_ID_o=%b want 00 and known", r_valid_o, r_ID_o);
    else pass_cnt++;
  endtask

  task automatic test_in_order();
    data_req_i = 1'b1;
    data_gnt_i = 1'b1;
    ID_i       = 3'd3;
    #1;
    total_cnt++;
    if (data_req_o !== 1'b1 || data_gnt_o !== 1'b1)
      $display("FAIL pass_hs got req=%b gnt=%b want 1 1", data_req_o, data_gnt_o);
    else pass_cnt++;
    tick();
    ID_i = 3'd5;
    tick();
    idle();
    #1;
    total_cnt++;
    if (outstanding_o !== 3'd2) $display("FAIL ord_cnt2 got %0d want 2", outstanding_o);
    else pass_cnt++;
    r_valid_i = 1'b1;
    r_rdata_i = 32'hA;
    #1;
    total_cnt++;
    if (r_valid_o !== 8'h08 || r_rdata_o !== 32'hA || r_ID_o !== 3'd3)
      $display("FAIL ord_resp0 got %h/%h/%0d want 08/0000000a/3", r_valid_o, r_rdata_o, r_ID_o);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (outstanding_o !== 3'd1) $display("FAIL ord_cnt1 got %0d want 1", outstanding_o);
    else pass_cnt++;
    r_rdata_i = 32'hB;
    #1;
    total_cnt++;
    if (r_valid_o !== 8'h20 || r_rdata_o !== 32'hB || r_ID_o !== 3'd5)
      $display("FAIL ord_resp1 got %h/%h/%0d want 20/0000000b/5", r_valid_o, r_rdata_o, r_ID_o);
    else pass_cnt++;
    tick();
    idle();
    #1;
    total_cnt++;
    if (outstanding_o !== 3'd0 || empty_o !== 1'b1 || err_o !== 1'b0)
      $display("FAIL ord_end got cnt=%0d empty=%b err=%b want 0 1 0",
               outstanding_o, empty_o, err_o);
    else pass_cnt++;
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) push_id(3'(i));
    idle();
    #1;
    total_cnt++;
    if (full_o !== 1'b1 || outstanding_o !== 3'd4)
      $display("FAIL full_set got full=%b cnt=%0d want 1 4", full_o, outstanding_o);
    else pass_cnt++;
    data_req_i = 1'b1;
    data_gnt_i = 1'b1;
    ID_i       = 3'd6;
    #1;
    total_cnt++;
    if (data_gnt_o !== 1'b0 || data_req_o !== 1'b0)
      $display("FAIL full_mask got req=%b gnt=%b want 0 0", data_req_o, data_gnt_o);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (outstanding_o !== 3'd4) $display("FAIL full_hold got %0d want 4", outstanding_o);
    else pass_cnt++;
    // Pop while full with the request still pending: the slot frees only next cycle.
    r_valid_i = 1'b1;
    #1;
    total_cnt++;
    if (r_valid_o !== 8'h01 || data_gnt_o !== 1'b0)
      $display("FAIL full_pop got r_valid_o=%h gnt=%b want 01 0", r_valid_o, data_gnt_o);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (full_o !== 1'b0 || outstanding_o !== 3'd3)
      $display("FAIL full_clr got full=%b cnt=%0d want 0 3", full_o, outstanding_o);
    else pass_cnt++;
    idle();
    for (int i = 1; i < 4; i++) begin
      logic [7:0] exp_oh;
      exp_oh    = 8'd1 << i;
      r_valid_i = 1'b1;
      #1;
      total_cnt++;
      if (r_valid_o !== exp_oh)
        $display("FAIL full_drain%0d got %h want %h", i, r_valid_o, exp_oh);
      else pass_cnt++;
      tick();
    end
    idle();
    #1;
    total_cnt++;
    if (empty_o !== 1'b1 || err_o !== 1'b0)
      $display("FAIL full_end got empty=%b err=%b want 1 0", empty_o, err_o);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    push_id(3'd1);
    push_id(3'd2);
    data_req_i = 1'b1;
    data_gnt_i = 1'b1;
    ID_i       = 3'd7;
    r_valid_i  = 1'b1;
    #1;
    total_cnt++;
    if (r_valid_o !== 8'h02) $display("FAIL sim_pop got %h want 02", r_valid_o);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (outstanding_o !== 3'd2) $display("FAIL sim_cnt got %0d want 2", outstanding_o);
    else pass_cnt++;
    idle();
    r_valid_i = 1'b1;
    #1;
    total_cnt++;
    if (r_valid_o !== 8'h04) $display("FAIL sim_next got %h want 04", r_valid_o);
    else pass_cnt++;
    tick();
    #1;
    total_cnt++;
    if (r_valid_o !== 8'h80 || r_ID_o !== 3'd7)
      $display("FAIL sim_id7 got %h/%0d want 80/7", r_valid_o, r_ID_o);
    else pass_cnt++;
    tick();
    idle();
    #1;
    total_cnt++;
    if (empty_o !== 1'b1 || err_o !== 1'b0)
      $display("FAIL sim_end got empty=%b err=%b want 1 0", empty_o, err_o);
    else pass_cnt++;
  endtask

  task automatic test_error();
    r_valid_i = 1'b1;
    r_rdata_i = 32'hC;
    #1;
    total_cnt++;
    if (r_valid_o !== 8'h00 || err_o !== 1'b0)
      $display("FAIL err_drop got r_valid_o=%h err=%b want 00 0", r_valid_o, err_o);
    else pass_cnt++;
    tick();
    idle();
    #1;
    total_cnt++;
    if (err_o !== 1'b1) $display("FAIL err_set got %b want 1", err_o);
    else pass_cnt++;
    push_id(3'd2);
    idle();
    r_valid_i = 1'b1;
    #1;
    total_cnt++;
    if (r_valid_o !== 8'h04) $display("FAIL err_route got %h want 04", r_valid_o);
    else pass_cnt++;
    tick();
    idle();
    tick();
    tick();
    total_cnt++;
    if (err_o !== 1'b1) $display("FAIL err_sticky got %b want 1", err_o);
    else pass_cnt++;
    do_reset();
    #1;
    total_cnt++;
    if (err_o !== 1'b0) $display("FAIL err_clr got %b want 0", err_o);
    else pass_cnt++;
    // Push and response together on an empty tracker: no bypass, counts as an error.
    data_req_i = 1'b1;
    data_gnt_i = 1'b1;
    ID_i       = 3'd4;
    r_valid_i  = 1'b1;
    #1;
    total_cnt++;
    if (r_valid_o !== 8'h00) $display("FAIL nobyp_oh got %h want 00", r_valid_o);
    else pass_cnt++;
    tick();
    idle();
    #1;
    total_cnt++;
    if (err_o !== 1'b1 || outstanding_o !== 3'd1)
      $display("FAIL nobyp_state got err=%b cnt=%0d want 1 1", err_o, outstanding_o);
    else pass_cnt++;
    r_valid_i = 1'b1;
    #1;
    total_cnt++;
    if (r_valid_o !== 8'h10) $display("FAIL nobyp_route got %h want 10", r_valid_o);
    else pass_cnt++;
    tick();
    do_reset();
  endtask

  task automatic test_reset_mid();
    push_id(3'd5);
    push_id(3'd6);
    push_id(3'd7);
    do_reset();
    #1;
    total_cnt++;
    if (outstanding_o !== 3'd0 || empty_o !== 1'b1 || err_o !== 1'b0)
      $display("FAIL mid_rst got cnt=%0d empty=%b err=%b want 0 1 0",
               outstanding_o, empty_o, err_o);
    else pass_cnt++;
    push_id(3'd1);
    idle();
    r_valid_i = 1'b1;
    #1;
    total_cnt++;
    if (r_valid_o !== 8'h02 || r_ID_o !== 3'd1)
      $display("FAIL mid_route got %h/%0d want 02/1", r_valid_o, r_ID_o);
    else pass_cnt++;
    tick();
    idle();
    #1;
    total_cnt++;
    if (empty_o !== 1'b1 || err_o !== 1'b0)
      $display("FAIL mid_empty got empty=%b err=%b want 1 0", empty_o, err_o);
    else pass_cnt++;
    r_valid_i = 1'b1;
    tick();
    idle();
    #1;
    total_cnt++;
    if (err_o !== 1'b1) $display("FAIL mid_err got %b want 1", err_o);
    else pass_cnt++;
    do_reset();
  endtask

  task automatic test_stream();
    // Overlapped push of ID i with pop of ID i-1; ten entries wrap the 4-deep pointers.
    for (int i = 0; i <= 10; i++) begin
      logic [7:0] exp_oh;
      data_req_i = (i < 10);
      data_gnt_i = (i < 10);
      ID_i       = 3'(i % 8);
      r_valid_i  = (i > 0);
      r_rdata_i  = 32'(i);
      #1;
      if (i > 0) begin
        exp_oh = 8'd1 << ((i - 1) % 8);
        total_cnt++;
        if (r_valid_o !== exp_oh || r_rdata_o !== 32'(i))
          $display("FAIL stream%0d got %h/%0d want %h/%0d", i, r_valid_o, r_rdata_o, exp_oh, i);
        else pass_cnt++;
      end
      tick();
      if (i == 5) begin
        total_cnt++;
        if (outstanding_o !== 3'd1) $display("FAIL stream_cnt got %0d want 1", outstanding_o);
        else pass_cnt++;
      end
    end
    idle();
    #1;
    total_cnt++;
    if (empty_o !== 1'b1 || err_o !== 1'b0 || outstanding_o !== 3'd0)
      $display("FAIL stream_end got empty=%b err=%b cnt=%0d want 1 0 0",
               empty_o, err_o, outstanding_o);
    else pass_cnt++;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    test_reset();
    test_in_order();
    test_full();
    test_simultaneous();
    test_error();
    test_reset_mid();
    test_stream();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/resp_id_tracker.md
RESP_ID_TRACKER -- requirements
Module: resp_id_tracker

Interface
REQ-001 Param N_MASTER, default 8: number of initiators behind the arbitration tree.
REQ-002 Param ID_WIDTH, default 3: initiator ID width; SHALL equal clog2(N_MASTER).
REQ-003 Param DATA_WIDTH, default 32: response data width.
REQ-004 Param DEPTH, default 4: max outstanding requests; power of two, >= 2.
REQ-005 Param CNT_WIDTH, default 3: outstanding counter width; SHALL equal clog2(DEPTH+1).
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-008 data_req_i  in  1  request from arbiter winner.
REQ-009 ID_i  in  ID_WIDTH  initiator ID of winning request.
REQ-010 data_gnt_i  in  1  grant from TCDM target.
REQ-011 data_req_o  out  1  request forwarded to target.
REQ-012 data_gnt_o  out  1  grant returned to arbiter.
REQ-013 r_valid_i  in  1  response valid from target.
REQ-014 r_rdata_i  in  DATA_WIDTH  response data from target.
REQ-015 r_valid_o  out  N_MASTER  one-hot response valid per initiator.
REQ-016 r_rdata_o  out  DATA_WIDTH  response data, broadcast.
REQ-017 r_ID_o  out  ID_WIDTH  ID of initiator receiving current response.
REQ-018 outstanding_o  out  CNT_WIDTH  accepted-but-unanswered request count.
REQ-019 full_o / empty_o  out  1 each  tracker full (count==DEPTH) / empty (count==0).
REQ-020 err_o  out  1  sticky: response received with no outstanding request.

Function
REQ-021 data_req_o = data_req_i & ~full_o; data_gnt_o = data_gnt_i & ~full_o (combinational).
REQ-022 Push: when data_req_o & data_gnt_i, ID_i written at write pointer; pointer advances modulo DEPTH.
REQ-023 Pop: when r_valid_i & ~empty_o, head entry retired; read pointer advances modulo DEPTH.
REQ-024 Responses are in order: the k-th response SHALL route to the k-th accepted ID.
REQ-025 r_valid_o = one-hot(head ID) when r_valid_i & ~empty_o, else all zero; zero-cycle latency from r_valid_i.
REQ-026 r_rdata_o = r_rdata_i unconditionally; r_ID_o = head ID (don't-care value when empty, but SHALL be deterministic).
REQ-027 Counter: +1 on push only, -1 on pop only, unchanged on both or neither; never exceeds DEPTH or goes below 0.
REQ-028 Full: no push possible (req/gnt masked); a pop in the same cycle clears full on next cycle, no bypass.
REQ-029 Empty: a push and r_valid_i in the same cycle SHALL NOT bypass; r_valid_i is treated as error (min response latency 1 cycle).
REQ-030 r_valid_i while empty: response dropped, r_valid_o all zero, err_o set next cycle and held until reset.
REQ-031 Pointer wrap: DEPTH-1 -> 0; counter distinguishes full from empty (no pointer-equality ambiguity).
REQ-032 ID_i is stored only on push; held entries are not affected by ID_i changes.

Reset
REQ-033 On rst_n==0 at a clock edge: pointers 0, count 0, err_o 0, empty_o 1, full_o 0; storage contents need not be cleared.
REQ-034 Reset mid-operation discards all outstanding entries; a r_valid_i after reset with no push sets err_o.
REQ-035 During reset cycle no push or pop takes effect, regardless of inputs.

Verification
REQ-036 Push IDs 3,5 (req=gnt=1, two cycles), then r_valid_i with data 0xA, 0xB -> r_valid_o=0x08 data 0xA, then 0x20 data 0xB; outstanding 2->1->0.
REQ-037 Push 4 entries with DEPTH=4 -> full_o=1, data_gnt_o=0 despite data_gnt_i=1; 5th request not stored; one pop -> full_o=0 next cycle.
REQ-038 Simultaneous push ID 7 and pop with count 2 -> count stays 2, popped head routed, ID 7 returned after remaining entry.
REQ-039 r_valid_i=1 with empty tracker -> r_valid_o=0, err_o=1 next cycle and stays 1 until rst_n=0.
REQ-040 Fill 3 entries, assert rst_n=0 one cycle -> outstanding_o=0, empty_o=1, err_o=0; subsequent push/pop of ID 1 routes r_valid_o=0x02.
REQ-041 Stream 10 push/pop pairs with IDs 0..7 cycling -> pointers wrap, order preserved, no err_o.
